// File: rtl/shift_pipe.sv
// Two-stage valid/ready barrel shifter (SRL, SRA, SLL). Stage 1 does the byte-granular
// coarse shift, stage 2 the bit-granular fine shift, and its register drives the output.
module shift_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data,
   input  logic [4:0]       shamt,
   input  logic [1:0]       op,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam logic [1:0] OP_SRA = 2'b01;
   localparam logic [1:0] OP_SLL = 2'b10;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [2:0]       s1_fine;
   logic             s1_fill;
   logic             s1_rev;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;

   logic             s1_adv;
   logic             s2_adv;

   logic             rev_in;
   logic             fill_in;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] coarse;
   logic [WIDTH-1:0] fine;
   logic [WIDTH-1:0] s2_next;

   function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = x[WIDTH-1-i];
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] shift_right_fill(input logic [WIDTH-1:0] x,
                                                         input logic [4:0]       amt,
                                                         input logic             fill);
      logic [2*WIDTH-1:0] ext;
      ext = {{WIDTH{fill}}, x} >> amt;
      return ext[WIDTH-1:0];
   endfunction

   // SLL is done as a right shift on the bit-reversed operand, undone after stage 2.
   always_comb begin
      rev_in  = (op == OP_SLL);
      fill_in = (op == OP_SRA) ? data[WIDTH-1] : 1'b0;
      operand = rev_in ? bit_reverse(data) : data;
      coarse  = shift_right_fill(operand, {shamt[4:3], 3'b000}, fill_in);
   end

   always_comb begin
      fine    = shift_right_fill(s1_data, {2'b00, s1_fine}, s1_fill);
      s2_next = s1_rev ? bit_reverse(fine) : fine;
   end

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;
   assign result    = s2_data;

   // Flush is applied last so it wins over any load in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_fine  <= '0;
         s1_fill  <= 1'b0;
         s1_rev   <= 1'b0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_data <= coarse;
               s1_fine <= shamt[2:0];
               s1_fill <= fill_in;
               s1_rev  <= rev_in;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s2_next;
            end
         end
         if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
         end
      end
   end

endmodule
